// File: rtl/systolic_sequencer.sv
// Systolic array sequencer: loads a weight tile, streams skewed activation
// columns into the array and re-aligns the skewed result lanes into columns.
module systolic_sequencer #(
    parameter int unsigned ACTIVATION_COUNT = 16,
    parameter int unsigned WEIGHT_COUNT     = 16,
    parameter int unsigned ARRAY_LATENCY    = ACTIVATION_COUNT + 1,
    parameter int unsigned COL_MAX          = 256,
    parameter int unsigned DATA_W           = 32
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        start_i,
    input  logic [$clog2(COL_MAX+1)-1:0]                cols_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    input  logic                                        w_valid_i,
    output logic                                        w_ready_o,
    input  logic [WEIGHT_COUNT-1:0][DATA_W-1:0]         w_col_i,
    input  logic                                        a_valid_i,
    output logic                                        a_ready_o,
    input  logic [ACTIVATION_COUNT-1:0][DATA_W-1:0]     a_col_i,
    output logic                                        weight_update_o,
    output logic [WEIGHT_COUNT-1:0][DATA_W-1:0]         weight_o,
    output logic [ACTIVATION_COUNT-1:0][DATA_W-1:0]     activation_o,
    input  logic [WEIGHT_COUNT-1:0][DATA_W-1:0]         result_i,
    output logic                                        res_valid_o,
    output logic [WEIGHT_COUNT-1:0][DATA_W-1:0]         res_o
);

    localparam int unsigned CW = $clog2(COL_MAX + 1);
    localparam int unsigned KW = $clog2(ACTIVATION_COUNT + 1);
    localparam int unsigned TL = ARRAY_LATENCY + WEIGHT_COUNT;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cols_q, cols_d;
    logic [CW-1:0]   a_cnt_q, a_cnt_d;
    logic [KW-1:0]   w_cnt_q, w_cnt_d;
    logic [TL-1:0]   tag_q;
    logic            w_acc, a_acc;
    logic            weight_update_q;
    logic [WEIGHT_COUNT-1:0][DATA_W-1:0] weight_q;

    assign w_acc = w_valid_i & w_ready_o;
    assign a_acc = a_valid_i & a_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cols_q  <= '0;
            a_cnt_q <= '0;
            w_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            a_cnt_q <= a_cnt_d;
            w_cnt_q <= w_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        a_cnt_d = a_cnt_q;
        w_cnt_d = w_cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = LOAD_W;
                cols_d  = cols_i;
                a_cnt_d = '0;
                w_cnt_d = '0;
            end
            LOAD_W: if (w_acc) begin
                if (w_cnt_q == KW'(ACTIVATION_COUNT - 1)) begin
                    state_d = (cols_q != '0) ? STREAM : DRAIN;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = w_cnt_q + KW'(1);
                end
            end
            STREAM: if (a_acc) begin
                a_cnt_d = a_cnt_q + CW'(1);
                if (a_cnt_q + CW'(1) == cols_q) state_d = DRAIN;
            end
            DRAIN: if (tag_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        w_ready_o = (state_q == LOAD_W);
        a_ready_o = (state_q == STREAM);
        done_o    = (state_q == DRAIN) && (tag_q == '0);
    end

    // The tag shift register is exactly as long as the column round trip,
    // so its last stage doubles as the result-valid strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            weight_update_q <= 1'b0;
            weight_q        <= '0;
            tag_q           <= '0;
        end else begin
            weight_update_q <= w_acc;
            if (w_acc) weight_q <= w_col_i;
            tag_q <= {tag_q[TL-2:0], a_acc};
        end
    end

    assign weight_update_o = weight_update_q;
    assign weight_o        = weight_q;
    assign res_valid_o     = tag_q[TL-1];

    for (genvar i = 0; i < ACTIVATION_COUNT; i++) begin : g_skew
        localparam int unsigned DEPTH = i + 1;
        logic [DATA_W-1:0] pipe_q [DEPTH];
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int unsigned s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
            end else begin
                pipe_q[0] <= a_acc ? a_col_i[i] : '0;
                for (int unsigned s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
            end
        end
        assign activation_o[i] = pipe_q[DEPTH-1];
    end

    for (genvar z = 0; z < WEIGHT_COUNT; z++) begin : g_deskew
        localparam int unsigned DEPTH = WEIGHT_COUNT - 1 - z;
        logic [DATA_W-1:0] lane;
        if (DEPTH == 0) begin : g_pass
            assign lane = result_i[z];
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe_q [DEPTH];
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int unsigned s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
                end else begin
                    pipe_q[0] <= result_i[z];
                    for (int unsigned s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
                end
            end
            assign lane = pipe_q[DEPTH-1];
        end
        // Gated so the output reads zero whenever no column is presented.
        assign res_o[z] = res_valid_o ? lane : '0;
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural array model plus a matrix-product
// scoreboard checked every cycle, with directed and randomized jobs.
module tb_systolic_sequencer;

    localparam int N    = 4;
    localparam int L    = 5;
    localparam int DW   = 32;
    localparam int CMAX = 16;
    localparam int CW   = $clog2(CMAX + 1);

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] cols_i = '0;
    logic          busy_o, done_o;
    logic          w_valid_i = 1'b0, w_ready_o;
    logic          a_valid_i = 1'b0, a_ready_o;
    vec_t          w_col_i = '0, a_col_i = '0;
    logic          weight_update_o, res_valid_o;
    vec_t          weight_o, activation_o, res_o;
    vec_t          result_i = '0;

    always #5 clk_i = ~clk_i;

    systolic_sequencer #(
        .ACTIVATION_COUNT(N), .WEIGHT_COUNT(N), .ARRAY_LATENCY(L),
        .COL_MAX(CMAX), .DATA_W(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cols_i(cols_i),
        .busy_o(busy_o), .done_o(done_o),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_col_i(w_col_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_col_i(a_col_i),
        .weight_update_o(weight_update_o), .weight_o(weight_o),
        .activation_o(activation_o), .result_i(result_i),
        .res_valid_o(res_valid_o), .res_o(res_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rv();
        int v;
        v = int'($urandom_range(0, 16382)) - 8191;
        return v;
    endfunction

    // Bench-side matrices: wm[z][k] = W(row z, K index k); acol[j] = column j of A.
    logic [DW-1:0] wm [N][N];
    vec_t          acol [CMAX];

    // Behavioural array: result lane z at cycle n = sum_k W[z][k] * activation
    // lane k seen at cycle (n - L - z + k), using the last N weight loads.
    int            cyc = 0;
    logic [DW-1:0] hist [64][N];
    vec_t          wload [$];

    initial begin
        for (int c = 0; c < 64; c++)
            for (int k = 0; k < N; k++) hist[c][k] = '0;
    end

    always @(posedge clk_i) begin
        logic [DW-1:0] acc;
        int c;
        #1;
        cyc++;
        if (weight_update_o) begin
            wload.push_back(weight_o);
            if (wload.size() > N) void'(wload.pop_front());
        end
        for (int k = 0; k < N; k++) hist[cyc % 64][k] = activation_o[k];
        for (int z = 0; z < N; z++) begin
            acc = '0;
            for (int k = 0; k < N; k++) begin
                c = cyc - L - z + k;
                if (c >= 1 && wload.size() == N) acc = acc + wload[N-1-k][z] * hist[c % 64][k];
            end
            result_i[z] = acc;
        end
    end

    // Scoreboard: an accepted column in cycle t must emerge at t+L+N as W*a.
    typedef struct { int due; vec_t col; } exp_t;
    exp_t sb [$];
    int   res_cyc [$];
    vec_t res_val [$];
    int   done_cnt = 0, done_cyc = 0, wu_cnt = 0;
    bit   w_acc_prev = 1'b0;
    vec_t w_prev = '0;
    bit   exp_v;

    always @(negedge clk_i) begin
        vec_t e;
        if (!rst_i) begin
            sb.delete();
            w_acc_prev = 1'b0;
        end else begin
            check("weight_update_o", weight_update_o, w_acc_prev);
            if (w_acc_prev) begin
                check("weight_o", weight_o, w_prev);
                wu_cnt++;
            end
            w_acc_prev = w_valid_i && w_ready_o;
            w_prev     = w_col_i;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("res_valid_o", res_valid_o, exp_v);
            if (res_valid_o) begin
                res_cyc.push_back(cyc);
                res_val.push_back(res_o);
            end
            if (exp_v) begin
                check("res_o", res_o, sb[0].col);
                void'(sb.pop_front());
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (a_valid_i && a_ready_o) begin
                for (int z = 0; z < N; z++) begin
                    e[z] = '0;
                    for (int k = 0; k < N; k++) e[z] = e[z] + wm[z][k] * a_col_i[k];
                end
                sb.push_back('{cyc + L + N, e});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " busy_o"}, busy_o, 0);
        check({tag, " done_o"}, done_o, 0);
        check({tag, " w_ready_o"}, w_ready_o, 0);
        check({tag, " a_ready_o"}, a_ready_o, 0);
        check({tag, " weight_update_o"}, weight_update_o, 0);
        check({tag, " weight_o"}, weight_o, 0);
        check({tag, " activation_o"}, activation_o, 0);
        check({tag, " res_valid_o"}, res_valid_o, 0);
        check({tag, " res_o"}, res_o, 0);
    endtask

    task automatic run_job(input int ncols, input int wgap_at, input int wgap_len,
                           input int agap_at, input int agap_len, input bit rnd_gaps,
                           input bit start_hold, input int abort_after,
                           output int t0, output int last_wacc);
        int m, j, gl, budget;
        bit acc;
        wu_cnt = 0; done_cnt = 0; t0 = -1; last_wacc = -1;
        res_cyc.delete(); res_val.delete();
        start_i = 1'b1;
        cols_i  = CW'(ncols);
        @(posedge clk_i); #1;
        if (!start_hold) start_i = 1'b0;
        cols_i = CW'($urandom_range(0, CMAX));
        m = 0; gl = wgap_len; budget = 0;
        while (m < N && budget < 100) begin
            if (m == wgap_at && gl > 0) begin
                w_valid_i = 1'b0; gl--;
                for (int z = 0; z < N; z++) w_col_i[z] = rv();
            end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                w_valid_i = 1'b0;
                for (int z = 0; z < N; z++) w_col_i[z] = rv();
            end else begin
                w_valid_i = 1'b1;
                for (int z = 0; z < N; z++) w_col_i[z] = wm[z][N-1-m];
            end
            @(negedge clk_i);
            acc = w_valid_i && w_ready_o;
            if (acc) last_wacc = cyc;
            @(posedge clk_i); #1;
            if (acc) m++;
            budget++;
        end
        w_valid_i = 1'b0;
        start_i   = 1'b0;
        check("weight columns accepted", m, N);
        j = 0; gl = agap_len; budget = 0;
        while (j < ncols && budget < 200 && !(abort_after > 0 && j == abort_after)) begin
            if ((j == agap_at && gl > 0) || (rnd_gaps && $urandom_range(0, 3) == 0)) begin
                if (j == agap_at && gl > 0) gl--;
                a_valid_i = 1'b0;
                for (int k = 0; k < N; k++) a_col_i[k] = rv();
            end else begin
                a_valid_i = 1'b1;
                a_col_i   = acol[j];
            end
            @(negedge clk_i);
            acc = a_valid_i && a_ready_o;
            if (acc && t0 < 0) t0 = cyc;
            @(posedge clk_i); #1;
            if (acc) j++;
            budget++;
        end
        a_valid_i = 1'b0;
        if (abort_after > 0) begin
            #2 rst_i = 1'b0;
            #1 check_all_zero("async reset");
            @(negedge clk_i);
            @(posedge clk_i); #1 rst_i = 1'b1;
            repeat (25) @(posedge clk_i);
            check("no done_o after abort", done_cnt, 0);
            check("no res_valid_o after abort", res_cyc.size(), 0);
        end else begin
            check("activation columns accepted", j, ncols);
            budget = 0;
            while (done_cnt == 0 && budget < 200) begin
                @(posedge clk_i);
                budget++;
            end
            repeat (3) @(posedge clk_i);
            #1;
            check("done_o pulse count", done_cnt, 1);
            check("busy_o after done", busy_o, 0);
            check("results emitted", res_cyc.size(), ncols);
            check("scoreboard drained", sb.size(), 0);
            if (ncols > 0 && res_cyc.size() > 0)
                check("done_o one cycle after last result", done_cyc, res_cyc[res_cyc.size()-1] + 1);
        end
    endtask

    task automatic random_operands(input int ncols);
        for (int z = 0; z < N; z++)
            for (int k = 0; k < N; k++) wm[z][k] = rv();
        for (int j = 0; j < ncols; j++)
            for (int k = 0; k < N; k++) acol[j][k] = rv();
    endtask

    initial begin
        int t0, lw;
        repeat (3) @(posedge clk_i);
        #1 check_all_zero("in reset");
        rst_i = 1'b1;
        @(posedge clk_i); #1 check_all_zero("after release");

        // Identity weights, back-to-back columns: results are the inputs.
        random_operands(4);
        for (int z = 0; z < N; z++)
            for (int k = 0; k < N; k++) wm[z][k] = (z == k) ? 32'd1 : 32'd0;
        run_job(4, -1, 0, -1, 0, 1'b0, 1'b0, 0, t0, lw);
        check("identity results count", res_val.size(), 4);
        if (res_val.size() == 4) begin
            check("identity first result cycle", res_cyc[0], t0 + 9);
            check("identity last result cycle", res_cyc[3], t0 + 12);
            for (int j = 0; j < 4; j++) check("identity res_o column", res_val[j], acol[j]);
        end
        check("identity done cycle", done_cyc, t0 + 13);

        // Weight valid dropped for three cycles mid-load.
        random_operands(4);
        run_job(4, 2, 3, -1, 0, 1'b0, 1'b0, 0, t0, lw);
        check("weight_update pulses", wu_cnt, 4);

        // Two-cycle activation bubble between columns 1 and 2.
        random_operands(4);
        run_job(4, -1, 0, 2, 2, 1'b0, 1'b0, 0, t0, lw);
        if (res_cyc.size() == 4) begin
            check("result spacing 0->1", res_cyc[1] - res_cyc[0], 1);
            check("result spacing 1->2", res_cyc[2] - res_cyc[1], 3);
            check("result spacing 2->3", res_cyc[3] - res_cyc[2], 1);
        end

        // Zero columns, with start_i held high while busy.
        random_operands(1);
        run_job(0, -1, 0, -1, 0, 1'b0, 1'b1, 0, t0, lw);
        check("cols0 weight_update pulses", wu_cnt, 4);
        check("cols0 done cycle", done_cyc, lw + 1);

        // Reset in the middle of streaming, then a clean job.
        random_operands(4);
        run_job(4, -1, 0, -1, 0, 1'b0, 1'b0, 2, t0, lw);
        random_operands(4);
        run_job(4, -1, 0, -1, 0, 1'b0, 1'b0, 0, t0, lw);

        // Randomized jobs with random handshake bubbles.
        for (int r = 0; r < 8; r++) begin
            int nc;
            nc = int'($urandom_range(1, CMAX));
            random_operands(nc);
            run_job(nc, -1, 0, -1, 0, 1'b1, r[0], 0, t0, lw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
